// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle sequencer.
// Holds the state encoding, instruction classes, ALUOp codes and the opcode
// constants and masks used by the class decoder.
package multicycle_ctrl_pkg;

    // Debug-visible encoding: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // ILLEGAL is the all-zero code so a cleared class register means "nothing decoded"
    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_RTYPE   = 3'd1,
        CL_LDUR    = 3'd2,
        CL_STUR    = 3'd3,
        CL_CBZ     = 3'd4,
        CL_B       = 3'd5
    } op_class_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CBZ and B carry immediate bits inside instruction[31:21]; compare only the fixed part
    localparam logic [10:0] OP_CBZ_PAT  = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [10:0] OP_B_PAT    = 11'b00010100000;
    localparam logic [10:0] OP_B_MASK   = 11'b11111100000;

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode-to-class decoder.
// Ports: opcode (instruction[31:21]) in, op_class out; anything unrecognised is ILLEGAL.
module multicycle_ctrl_opclass
    import multicycle_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   op_class
);

    // Exact matches first, then the masked branch formats
    always_comb begin
        op_class = CL_ILLEGAL;
        if ((opcode == OP_ADD) || (opcode == OP_SUB) ||
            (opcode == OP_AND) || (opcode == OP_ORR)) begin
            op_class = CL_RTYPE;
        end else if (opcode == OP_LDUR) begin
            op_class = CL_LDUR;
        end else if (opcode == OP_STUR) begin
            op_class = CL_STUR;
        end else if ((opcode & OP_CBZ_MASK) == OP_CBZ_PAT) begin
            op_class = CL_CBZ;
        end else if ((opcode & OP_B_MASK) == OP_B_PAT) begin
            op_class = CL_B;
        end else begin
            op_class = CL_ILLEGAL;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multi-cycle control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on the
// instruction and data memory ready handshakes with a timeout, counts retired
// instructions and halts (sticky) on an illegal opcode or a memory timeout.
// Ports:
//   clock, reset_n (synchronous, active-low), run (FETCH gate), opcode, zero,
//   imem_ready, dmem_ready                      -- inputs
//   ir_write, pc_write, en_jump, reg2loc, alusrc, memtoreg, regwrite,
//   readmem_en, writemem_en, aluop              -- datapath controls
//   state, retire, retired_cnt, halted, illegal, bus_err -- status
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TMO_CYC = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             en_jump,
    output logic             reg2loc,
    output logic             alusrc,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             readmem_en,
    output logic             writemem_en,
    output logic [1:0]       aluop,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    state_t           state_r;
    op_class_t        class_r;
    op_class_t        class_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [CNT_W-1:0] retired_cnt_r;
    logic             halted_r;
    logic             illegal_r;
    logic             bus_err_r;
    logic             tmo_last_s;

    multicycle_ctrl_opclass u_opclass (
        .opcode   (opcode),
        .op_class (class_s)
    );

    // The current wait cycle is the last one allowed; a ready in this cycle still wins
    assign tmo_last_s = (tmo_cnt_r == TMO_W'(TMO_CYC - 1));

    // Sequencer: state, class latch, wait timeout, retire counter and sticky halt causes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= ST_FETCH;
            class_r       <= CL_ILLEGAL;
            tmo_cnt_r     <= '0;
            retired_cnt_r <= '0;
            halted_r      <= 1'b0;
            illegal_r     <= 1'b0;
            bus_err_r     <= 1'b0;
        end else begin
            if (retire) begin
                retired_cnt_r <= retired_cnt_r + CNT_W'(1);
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end

            case (state_r)
                ST_FETCH: begin
                    if (!run) begin
                        tmo_cnt_r <= '0;
                    end else if (imem_ready) begin
                        tmo_cnt_r <= '0;
                        state_r   <= ST_DECODE;
                    end else if (tmo_last_s) begin
                        tmo_cnt_r <= '0;
                        bus_err_r <= 1'b1;
                        halted_r  <= 1'b1;
                        state_r   <= ST_HALT;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_DECODE: begin
                    class_r   <= class_s;
                    tmo_cnt_r <= '0;
                    if (class_s == CL_ILLEGAL) begin
                        illegal_r <= 1'b1;
                        halted_r  <= 1'b1;
                        state_r   <= ST_HALT;
                    end else begin
                        state_r   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (class_r)
                        CL_RTYPE:        state_r <= ST_WB;
                        CL_LDUR, CL_STUR: state_r <= ST_MEM;
                        CL_CBZ, CL_B:    state_r <= ST_FETCH;
                        default: begin
                            illegal_r <= 1'b1;
                            halted_r  <= 1'b1;
                            state_r   <= ST_HALT;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        tmo_cnt_r <= '0;
                        state_r   <= (class_r == CL_LDUR) ? ST_WB : ST_FETCH;
                    end else if (tmo_last_s) begin
                        tmo_cnt_r <= '0;
                        bus_err_r <= 1'b1;
                        halted_r  <= 1'b1;
                        state_r   <= ST_HALT;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                ST_WB: begin
                    state_r <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    // Unreachable encodings park the controller rather than resume execution
                    halted_r <= 1'b1;
                    state_r  <= ST_HALT;
                end
            endcase
        end
    end

    // Datapath controls decoded from registered state and class only; the
    // handshake/flag inputs gate single strobes but opcode never reaches them
    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        en_jump     = 1'b0;
        reg2loc     = 1'b0;
        alusrc      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        readmem_en  = 1'b0;
        writemem_en = 1'b0;
        aluop       = ALUOP_ADD;
        retire      = 1'b0;
        case (state_r)
            ST_FETCH: begin
                ir_write = run & imem_ready;
            end
            ST_EXEC: begin
                reg2loc  = (class_r == CL_STUR) || (class_r == CL_CBZ);
                alusrc   = (class_r == CL_LDUR) || (class_r == CL_STUR);
                case (class_r)
                    CL_RTYPE: aluop = ALUOP_RTYPE;
                    CL_CBZ:   aluop = ALUOP_PASSB;
                    default:  aluop = ALUOP_ADD;
                endcase
                pc_write = (class_r == CL_CBZ) || (class_r == CL_B);
                retire   = (class_r == CL_CBZ) || (class_r == CL_B);
                en_jump  = (class_r == CL_B) || ((class_r == CL_CBZ) && zero);
            end
            ST_MEM: begin
                readmem_en  = (class_r == CL_LDUR);
                writemem_en = (class_r == CL_STUR);
                pc_write    = (class_r == CL_STUR) && dmem_ready;
                retire      = (class_r == CL_STUR) && dmem_ready;
            end
            ST_WB: begin
                regwrite = 1'b1;
                memtoreg = (class_r == CL_LDUR);
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            default: begin
                aluop = ALUOP_ADD;
            end
        endcase
    end

    assign state       = state_r;
    assign retired_cnt = retired_cnt_r;
    assign halted      = halted_r;
    assign illegal     = illegal_r;
    assign bus_err     = bus_err_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. A driver issues instructions with
// randomized wait states and pushes the expected per-cycle observation derived
// from the instruction-level latency rules; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO   = 6;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam int K_RTYPE = 0, K_LDUR = 1, K_STUR = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    typedef struct packed {
        logic [2:0]       state;
        logic             ir_write;
        logic             pc_write;
        logic             en_jump;
        logic             reg2loc;
        logic             alusrc;
        logic             memtoreg;
        logic             regwrite;
        logic             readmem_en;
        logic             writemem_en;
        logic [1:0]       aluop;
        logic             retire;
        logic [CNT_W-1:0] cnt;
        logic             halted;
        logic             illegal;
        logic             bus_err;
    } obs_t;

    logic clock, reset_n, run, zero, imem_ready, dmem_ready;
    logic [10:0] opcode;
    logic ir_write, pc_write, en_jump, reg2loc, alusrc, memtoreg, regwrite;
    logic readmem_en, writemem_en, retire, halted, illegal, bus_err;
    logic [1:0] aluop;
    logic [2:0] state;
    logic [CNT_W-1:0] retired_cnt;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: retired count and sticky flags as seen by the outside world
    int   m_cnt = 0;
    bit   m_halt = 1'b0, m_ill = 1'b0, m_berr = 1'b0;

    multicycle_ctrl #(.CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ir_write(ir_write),
        .pc_write(pc_write), .en_jump(en_jump), .reg2loc(reg2loc), .alusrc(alusrc),
        .memtoreg(memtoreg), .regwrite(regwrite), .readmem_en(readmem_en),
        .writemem_en(writemem_en), .aluop(aluop), .state(state), .retire(retire),
        .retired_cnt(retired_cnt), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: compare DUT outputs with the scoreboard every cycle an entry is queued
    always @(negedge clock) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.state = state;       a.ir_write = ir_write;     a.pc_write = pc_write;
            a.en_jump = en_jump;   a.reg2loc = reg2loc;       a.alusrc = alusrc;
            a.memtoreg = memtoreg; a.regwrite = regwrite;     a.readmem_en = readmem_en;
            a.writemem_en = writemem_en; a.aluop = aluop;     a.retire = retire;
            a.cnt = retired_cnt;   a.halted = halted;         a.illegal = illegal;
            a.bus_err = bus_err;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: got state=%0d ctl=%b aluop=%b ret=%b cnt=%0d flags=%b, expected state=%0d ctl=%b aluop=%b ret=%b cnt=%0d flags=%b",
                         vectors, $time, a.state,
                         {a.ir_write, a.pc_write, a.en_jump, a.reg2loc, a.alusrc, a.memtoreg, a.regwrite, a.readmem_en, a.writemem_en},
                         a.aluop, a.retire, a.cnt, {a.halted, a.illegal, a.bus_err},
                         e.state,
                         {e.ir_write, e.pc_write, e.en_jump, e.reg2loc, e.alusrc, e.memtoreg, e.regwrite, e.readmem_en, e.writemem_en},
                         e.aluop, e.retire, e.cnt, {e.halted, e.illegal, e.bus_err});
            end
        end
    end

    task automatic check_true(input bit cond, input string what);
        vectors++;
        if (!cond) begin
            miscompares++;
            $display("FAIL t=%0t: %s (state=%0d cnt=%0d flags=%b)",
                     $time, what, state, retired_cnt, {halted, illegal, bus_err});
        end
    endtask

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.state   = st;
        e.cnt     = CNT_W'(m_cnt % (1 << CNT_W));
        e.halted  = m_halt;
        e.illegal = m_ill;
        e.bus_err = m_berr;
        return e;
    endfunction

    function automatic bit is_legal(input logic [10:0] op);
        return (op == 11'b10001011000) || (op == 11'b11001011000) ||
               (op == 11'b10001010000) || (op == 11'b10101010000) ||
               (op == 11'b11111000010) || (op == 11'b11111000000) ||
               (op ==? 11'b10110100???) || (op ==? 11'b000101?????);
    endfunction

    function automatic logic [10:0] gen_op(input int kind);
        logic [10:0] op;
        logic [10:0] rt [4];
        rt[0] = 11'b10001011000; rt[1] = 11'b11001011000;
        rt[2] = 11'b10001010000; rt[3] = 11'b10101010000;
        case (kind)
            K_RTYPE: op = rt[$urandom_range(3, 0)];
            K_LDUR:  op = 11'b11111000010;
            K_STUR:  op = 11'b11111000000;
            K_CBZ:   op = {8'b10110100, 3'($urandom)};
            K_B:     op = {6'b000101, 5'($urandom)};
            default: begin
                op = 11'($urandom);
                while (is_legal(op)) op = 11'($urandom);
            end
        endcase
        return op;
    endfunction

    task automatic step(input obs_t e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_halt = 1'b0; m_ill = 1'b0; m_berr = 1'b0;
    endtask

    // One instruction: idle (run=0) cycles, fetch waits, then the class-specific path.
    // zsel: -1 random zero flag in EXEC, else forced value. rst_mem: reset at 2nd MEM cycle.
    task automatic run_instr(input int kind, input int iwait, input int dwait,
                             input int idle, input int zsel, input bit rst_mem,
                             input logic [10:0] op_force, input bit use_force);
        obs_t e;
        logic [10:0] op;
        bit rdy;
        op = use_force ? op_force : gen_op(kind);
        for (int k = 0; k < idle; k++) begin
            run = 1'b0; imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            zero = 1'($urandom); opcode = 11'($urandom);
            step(base(S_FETCH));
        end
        opcode = op; run = 1'b1;
        for (int k = 0; k < iwait; k++) begin
            imem_ready = 1'b0; dmem_ready = 1'($urandom); zero = 1'($urandom);
            step(base(S_FETCH));
            if (k == TMO - 1) begin
                m_halt = 1'b1; m_berr = 1'b1;
                check_true((state === S_HALT) && (halted === 1'b1) && (bus_err === 1'b1),
                           "fetch wait expired: expected HALT with bus_err");
                return;
            end
        end
        imem_ready = 1'b1;
        e = base(S_FETCH); e.ir_write = 1'b1;
        step(e);
        // DECODE: run and handshakes are don't-care here
        run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        step(base(S_DECODE));
        if (kind == K_ILL) begin
            m_halt = 1'b1; m_ill = 1'b1;
            return;
        end
        // EXEC: scramble opcode to show the class is held, not re-decoded
        opcode = 11'($urandom);
        zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        e = base(S_EXEC);
        e.reg2loc = (kind == K_STUR) || (kind == K_CBZ);
        e.alusrc  = (kind == K_LDUR) || (kind == K_STUR);
        e.aluop   = (kind == K_RTYPE) ? 2'b10 : ((kind == K_CBZ) ? 2'b01 : 2'b00);
        if (kind == K_CBZ || kind == K_B) begin
            e.pc_write = 1'b1;
            e.en_jump  = (kind == K_B) ? 1'b1 : zero;
            e.retire   = 1'b1;
        end
        step(e);
        if (kind == K_CBZ || kind == K_B) begin
            m_cnt++;
            return;
        end
        if (kind == K_LDUR || kind == K_STUR) begin
            for (int k = 0; k <= dwait; k++) begin
                rdy = (k == dwait);
                dmem_ready = rdy; zero = 1'($urandom); imem_ready = 1'($urandom);
                if (rst_mem && k == 1) reset_n = 1'b0;
                e = base(S_MEM);
                e.readmem_en  = (kind == K_LDUR);
                e.writemem_en = (kind == K_STUR);
                if (rdy && kind == K_STUR) begin
                    e.pc_write = 1'b1; e.retire = 1'b1;
                end
                step(e);
                if (rst_mem && k == 1) begin
                    reset_n = 1'b1;
                    model_reset();
                    return;
                end
                if (rdy) begin
                    if (kind == K_STUR) begin
                        m_cnt++;
                        return;
                    end
                    break;
                end else if (k == TMO - 1) begin
                    m_halt = 1'b1; m_berr = 1'b1;
                    check_true((state === S_HALT) && (halted === 1'b1) && (bus_err === 1'b1) &&
                               (retired_cnt === CNT_W'(m_cnt % (1 << CNT_W))),
                               "data wait expired: expected HALT with bus_err, count unchanged");
                    return;
                end
            end
        end
        dmem_ready = 1'($urandom);
        e = base(S_WB);
        e.regwrite = 1'b1; e.memtoreg = (kind == K_LDUR);
        e.pc_write = 1'b1; e.retire = 1'b1;
        step(e);
        m_cnt++;
    endtask

    // Stay halted for n cycles with random inputs, then reset out of HALT
    task automatic halt_then_reset(input int n);
        for (int k = 0; k < n; k++) begin
            run = 1'($urandom); imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom); zero = 1'($urandom); opcode = 11'($urandom);
            step(base(S_HALT));
        end
        reset_n = 1'b0;
        step(base(S_HALT));
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int kind, iw, dw;
        reset_n = 1'b0; run = 1'b0; zero = 1'b0; imem_ready = 1'b0;
        dmem_ready = 1'b0; opcode = 11'b0;
        repeat (2) @(posedge clock);
        #1;
        check_true((state === S_FETCH) && (retired_cnt === '0) &&
                   ({halted, illegal, bus_err} === 3'b000) &&
                   ({ir_write, pc_write, en_jump, reg2loc, alusrc, memtoreg, regwrite,
                     readmem_en, writemem_en, retire} === 10'b0) && (aluop === 2'b00),
                   "reset state");
        step(base(S_FETCH));               // reset state, reset still asserted
        reset_n = 1'b1;

        run_instr(K_RTYPE, 0, 0, 1, -1, 1'b0, 11'b10001011000, 1'b1);   // ADD
        run_instr(K_LDUR, 0, 3, 0, -1, 1'b0, 11'b0, 1'b0);              // 3 data waits
        run_instr(K_CBZ, 0, 0, 0, 1, 1'b0, 11'b0, 1'b0);
        run_instr(K_CBZ, 0, 0, 0, 0, 1'b0, 11'b0, 1'b0);
        run_instr(K_STUR, 1, 0, 0, -1, 1'b0, 11'b0, 1'b0);
        run_instr(K_B, 2, 0, 2, -1, 1'b0, 11'b0, 1'b0);
        run_instr(K_ILL, 0, 0, 0, -1, 1'b0, 11'b11111111111, 1'b1);
        halt_then_reset(20);
        run_instr(K_STUR, 0, TMO + 3, 0, -1, 1'b0, 11'b0, 1'b0);        // data timeout
        halt_then_reset(4);
        run_instr(K_LDUR, 0, 4, 0, -1, 1'b1, 11'b0, 1'b0);              // reset mid-MEM
        run_instr(K_RTYPE, TMO - 1, 0, 1, -1, 1'b0, 11'b0, 1'b0);       // ready on last fetch cycle
        run_instr(K_LDUR, 0, TMO - 1, 0, -1, 1'b0, 11'b0, 1'b0);        // ready on last mem cycle
        run_instr(K_RTYPE, TMO, 0, 0, -1, 1'b0, 11'b0, 1'b0);           // fetch timeout
        halt_then_reset(3);
        for (int i = 0; i < 18; i++) begin                               // counter wrap
            run_instr(($urandom_range(1, 0) == 0) ? K_B : K_CBZ, 0, 0, 0, -1, 1'b0, 11'b0, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            kind = ($urandom_range(15, 0) == 0) ? K_ILL : int'($urandom_range(4, 0));
            iw = ($urandom_range(9, 0) == 0) ? int'($urandom_range(TMO + 1, TMO - 1)) : int'($urandom_range(2, 0));
            dw = ($urandom_range(9, 0) == 0) ? int'($urandom_range(TMO + 1, TMO - 1)) : int'($urandom_range(3, 0));
            run_instr(kind, iw, dw, int'($urandom_range(1, 0)), -1, 1'b0, 11'b0, 1'b0);
            if (m_halt) halt_then_reset(int'($urandom_range(3, 1)));
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
